// File: rtl/arith_pkg.sv
// Shared definitions for the iterative arithmetic units.
//
// The FSM state encoding lives here so that every multi-cycle arithmetic
// block (multipliers, dividers, ...) uses the same values. Anything that
// decodes or monitors these units can then interpret state the same way
// for all of them.
//
// Contents:
//   arith_state_t  - IDLE=2'd0 (accepting operands), CALC=2'd1 (iterating),
//                    DONE=2'd2 (result held until consumed)
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } arith_state_t;

endpackage : arith_pkg

// File: rtl/ripple_carry_adder.sv
// Purely combinational ripple-carry adder of parameterisable width.
//
// Parameters:
//   nbit  - operand width in bits
// Ports:
//   a, b   input  [nbit-1:0]  addends
//   c_in   input  1           carry into bit 0
//   sum    output [nbit-1:0]  a + b + c_in, truncated to nbit bits
//   c_out  output 1           carry out of the top bit
module ripple_carry_adder #(
  parameter int nbit = 8
) (
  input  logic [nbit-1:0] a,
  input  logic [nbit-1:0] b,
  input  logic            c_in,
  output logic [nbit-1:0] sum,
  output logic            c_out
);

  // carry[i] is the carry into bit i; carry[nbit] is the final carry out.
  logic [nbit:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < nbit; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[nbit];

endmodule : ripple_carry_adder

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier with valid/ready handshakes.
//
// A single operand pair is taken in IDLE. CALC then runs one iteration per
// clock for NBIT clocks, adding the multiplicand into the high half when the
// current multiplier LSB is set and shifting the {H,Q} accumulator right by
// one. The 2*NBIT-bit result is held in DONE until the consumer takes it.
// After that the block returns to IDLE, so the minimum spacing between two
// accepted operand pairs is NBIT+2 cycles.
//
// Parameters:
//   NBIT       - operand width, 2..32
// Ports:
//   clk        input            rising-edge clock
//   rst        input            synchronous active-high reset
//   in_valid   input            a/b hold a valid operand pair
//   in_ready   output           block accepts operands (IDLE only)
//   a          input  [NBIT]    multiplicand, unsigned
//   b          input  [NBIT]    multiplier, unsigned
//   out_valid  output           product is valid (DONE only)
//   out_ready  input            consumer takes the product
//   product    output [2*NBIT]  a*b. After the handshake it keeps the last
//                               value until the next accept.
//   busy       output           high in CALC or DONE
module seq_multiplier
  import arith_pkg::*;
#(
  parameter int NBIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NBIT-1:0]   a,
  input  logic [NBIT-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*NBIT-1:0] product,
  output logic              busy
);

  // The counter must reach NBIT without wrapping.
  localparam int CNT_W = $clog2(NBIT + 1);

  arith_state_t state, state_next;

  logic [NBIT-1:0]  m_reg;   // latched multiplicand
  logic [NBIT-1:0]  h_reg;   // high half of the accumulator
  logic [NBIT-1:0]  q_reg;   // low half; starts out as the multiplier
  logic [CNT_W-1:0] cnt;     // CALC iterations completed

  logic [NBIT-1:0] addend;
  logic [NBIT-1:0] sum;
  logic            carry;
  logic            last_iter;
  logic            accept;

  // Partial-sum adder: H + (Q[0] ? M : 0).
  assign addend = q_reg[0] ? m_reg : '0;

  ripple_carry_adder #(
    .nbit (NBIT)
  ) u_adder (
    .a     (h_reg),
    .b     (addend),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (carry)
  );

  // The NBIT-th CALC edge is the one that sees the counter at NBIT-1.
  assign last_iter = (cnt == CNT_W'(NBIT - 1));
  assign accept    = (state == IDLE) && in_valid;

  // NOTE: state and datapath registers use non-blocking assignments, so
  // every register samples values from before the edge. That matters for
  // the {H,Q} shift, which reads q_reg while it also overwrites it.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case. If a
  // branch did not assign one of them, the tool would infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the datapath registers are cleared on reset as well as the state.
  // The product port shows {H,Q} directly, and it must read zero right after
  // a reset. The reset is synchronous and takes priority over the accept
  // logic, so a pair offered during reset is never latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg <= '0;
      h_reg <= '0;
      q_reg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      m_reg <= a;
      q_reg <= b;
      h_reg <= '0;
      cnt   <= '0;
    end else if (state == CALC) begin
      // The adder carry becomes the new MSB, so no result bit is lost.
      {h_reg, q_reg} <= {carry, sum, q_reg[NBIT-1:1]};
      cnt            <= cnt + CNT_W'(1);
    end
  end

  assign product = {h_reg, q_reg};

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (NBIT=8).
// Expected products are pushed to a queue when an operand pair is accepted.
// They are popped and compared when the DUT delivers a product.
module tb_seq_multiplier;

  localparam int NBIT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [NBIT-1:0]   a;
  logic [NBIT-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [2*NBIT-1:0] product;
  logic              busy;

  seq_multiplier #(.NBIT(NBIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int accept_cyc = 0;
  logic [2*NBIT-1:0] sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge. Inputs are driven, and outputs sampled, 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [2*NBIT-1:0] model(input logic [NBIT-1:0] x, input logic [NBIT-1:0] y);
    return (2*NBIT)'(x) * (2*NBIT)'(y);
  endfunction

  // Offer a pair while in IDLE and let the accepting edge pass.
  task automatic issue(input logic [NBIT-1:0] x, input logic [NBIT-1:0] y);
    check("in_ready_before_issue", in_ready, 1'b1);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    sb.push_back(model(x, y));
    tick();
    accept_cyc = cyc;
    in_valid   = 1'b0;
    check("busy_after_accept", busy, 1'b1);
  endtask

  // Wait for the product, optionally stall for 'hold' cycles, then consume it.
  task automatic collect(input int hold, input bit chk_lat);
    logic [2*NBIT-1:0] exp;
    int n;
    n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $error("FAIL out_valid_timeout: observed=0 expected=1 within 100 cycles");
      return;
    end
    if (chk_lat) check("latency", cyc - accept_cyc, NBIT);
    check("scoreboard_nonempty", sb.size() != 0, 1'b1);
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    check("product", product, exp);
    check("in_ready_in_done", in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_product", product, exp);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_out_valid", out_valid, 1'b0);
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("retained_product", product, exp);
  endtask

  initial begin
    int sent;
    int recv;
    bit acc;
    bit del;
    logic [2*NBIT-1:0] exp;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_product", product, 16'h0000);

    // Basic product and latency.
    issue(8'd13, 8'd11);
    collect(0, 1'b1);
    check("product_13x11", product, 16'h008F);

    // Boundary operands.
    issue(8'd255, 8'd255);
    collect(0, 1'b1);
    check("product_255x255", product, 16'hFE01);
    issue(8'd0, 8'd200);
    collect(0, 1'b1);
    issue(8'd200, 8'd0);
    collect(0, 1'b1);

    // Consumer stalls for 5 cycles in DONE.
    issue(8'd100, 8'd3);
    collect(5, 1'b1);

    // Operand and in_valid churn during CALC must be ignored.
    issue(8'd7, 8'd9);
    for (int i = 0; i < 6; i++) begin
      a        = 8'($urandom);
      b        = 8'($urandom);
      in_valid = ~in_valid;
      tick();
    end
    in_valid = 1'b0;
    collect(0, 1'b1);
    check("product_7x9", product, 16'd63);
    tick();
    check("no_second_accept", busy, 1'b0);

    // Reset on the 4th CALC edge; in_valid is high but must not be taken.
    issue(8'd50, 8'd60);
    tick();
    tick();
    tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 8'd9;
    b        = 8'd9;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    void'(sb.pop_back());
    check("midcalc_rst_in_ready", in_ready, 1'b1);
    check("midcalc_rst_out_valid", out_valid, 1'b0);
    check("midcalc_rst_product", product, 16'h0000);
    check("midcalc_rst_busy", busy, 1'b0);
    issue(8'd3, 8'd5);
    collect(0, 1'b1);
    check("product_3x5", product, 16'd15);

    // Reset in DONE while the consumer stalls.
    issue(8'd2, 8'd2);
    for (int i = 0; i < NBIT; i++) tick();
    check("done_before_rst", out_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    check("done_rst_out_valid", out_valid, 1'b0);
    check("done_rst_product", product, 16'h0000);

    // Random back-to-back stream with random consumer backpressure.
    sent = 0;
    recv = 0;
    for (int c = 0; c < 40000 && recv < 1000; c++) begin
      if (sent < 1000 && !in_valid) in_valid = 1'b1;
      if (!in_ready || in_valid) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      if ((c % 50) == 0) begin
        a = 8'hFF;
        b = 8'hFF;
      end
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        check("stream_sb_nonempty", sb.size() != 0, 1'b1);
        exp = (sb.size() != 0) ? sb.pop_front() : '0;
        check("stream_product", product, exp);
        recv++;
      end
      if (acc) begin
        sb.push_back(model(a, b));
        sent++;
      end
      tick();
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("stream_received", recv, 1000);
    check("stream_sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_multiplier
